// File: rtl/uart_rx.sv
// Oversampled UART receiver: start-bit validation, LSB-first data, optional even parity, framing/break handling.
// Build option: define UART_RX_PARITY_EN to expect an even parity bit between the data bits and the stop bit.
module uart_rx #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rx,
   input  logic                 tick,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 ferr,
   output logic                 perr,
   output logic                 busy
);

   localparam int PW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [PW-1:0] PH_MID   = PW'(OVERSAMPLE / 2 - 1);
   localparam logic [PW-1:0] PH_LAST  = PW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

   state_t               state, state_n;
   logic [PW-1:0]        phase, phase_n;
   logic [BW-1:0]        bit_idx, bit_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic [DATA_BITS-1:0] data_n;
   logic                 valid_n, ferr_n;
`ifdef UART_RX_PARITY_EN
   logic                 par_err, par_err_n;
   logic                 perr_n;
`endif

   assign busy = (state != IDLE);

   always_comb begin
      state_n = state;
      phase_n = phase;
      bit_n   = bit_idx;
      shreg_n = shreg;
      data_n  = data;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_n = par_err;
      perr_n    = 1'b0;
`endif
      if (tick) begin
         case (state)
            IDLE: begin
               if (!rx) begin
                  state_n = START;
                  phase_n = '0;
               end
            end
            START: begin
               phase_n = phase + PW'(1);
               // Mid-start sample rejects glitches shorter than half a bit.
               if (phase == PH_MID) begin
                  if (rx) begin
                     state_n = IDLE;
                  end else begin
                     state_n = DATA;
                     phase_n = '0;
                     bit_n   = '0;
`ifdef UART_RX_PARITY_EN
                     par_err_n = 1'b0;
`endif
                  end
               end
            end
            DATA: begin
               phase_n = (phase == PH_LAST) ? '0 : phase + PW'(1);
               if (phase == PH_LAST) begin
                  shreg_n = {rx, shreg[DATA_BITS-1:1]};
                  bit_n   = bit_idx + BW'(1);
                  if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_n = PARITY;
`else
                     state_n = STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               phase_n = (phase == PH_LAST) ? '0 : phase + PW'(1);
               if (phase == PH_LAST) begin
                  par_err_n = (^shreg) ^ rx;
                  state_n   = STOP;
               end
            end
`endif
            STOP: begin
               phase_n = (phase == PH_LAST) ? '0 : phase + PW'(1);
               if (phase == PH_LAST) begin
                  if (rx) begin
                     data_n  = shreg;
                     valid_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                     perr_n  = par_err;
`endif
                     state_n = IDLE;
                  end else begin
                     ferr_n  = 1'b1;
                     state_n = BREAK;
                  end
               end
            end
            BREAK: begin
               if (rx) state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         phase   <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         data    <= '0;
         valid   <= 1'b0;
         ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err <= 1'b0;
         perr    <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         phase   <= phase_n;
         bit_idx <= bit_n;
         shreg   <= shreg_n;
         data    <= data_n;
         valid   <= valid_n;
         ferr    <= ferr_n;
`ifdef UART_RX_PARITY_EN
         par_err <= par_err_n;
         perr    <= perr_n;
`endif
      end
   end

`ifndef UART_RX_PARITY_EN
   assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven tick-by-tick, expected strobes go to a queue checked by a monitor.
module tb_uart_rx;

   localparam int OS = 16;
   localparam int DB = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          rx    = 1'b1;
   logic          tick  = 1'b0;
   logic [DB-1:0] data;
   logic          valid, ferr, perr, busy;

   // entry = {ferr, perr, data}
   logic [DB+1:0] exp_q[$];
   int            n_cmp  = 0;
   int            n_fail = 0;

   uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
      .clock(clock), .reset(reset), .rx(rx), .tick(tick),
      .data(data), .valid(valid), .ferr(ferr), .perr(perr), .busy(busy)
   );

   // clock / tick generation: tick high for one clock in every four
   always #5 clock = ~clock;

   initial begin
      int tcnt;
      tcnt = 0;
      forever begin
         @(posedge clock);
         #1;
         tcnt = (tcnt + 1) % 4;
         tick = (tcnt == 0);
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         while (!tick) @(posedge clock);
      end
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      wait_ticks(OS);
   endtask

   task automatic send_frame(input logic [DB-1:0] d, input logic par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(par);
`else
      if (par) rx = 1'b1;
`endif
      send_bit(stop);
   endtask

   // scoreboard monitor
   initial begin
      logic [DB+1:0] exp;
      forever begin
         @(negedge clock);
         if (valid || ferr) begin
            check("valid_ferr_exclusive", {31'd0, valid & ferr}, 32'd0);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_strobe: got valid=%0b ferr=%0b data=0x%0h expected no strobe",
                        valid, ferr, data);
            end else begin
               exp = exp_q.pop_front();
               check("strobe_ferr_perr_data", {22'd0, ferr, perr, data}, {22'd0, exp});
            end
         end
      end
   end

   initial begin
      logic [DB-1:0] d5a;
      d5a = 8'h5A;

      // reset
      reset = 1'b1;
      rx    = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("reset_data",  {24'd0, data}, 32'd0);
      check("reset_valid", {31'd0, valid}, 32'd0);
      check("reset_ferr",  {31'd0, ferr}, 32'd0);
      check("reset_perr",  {31'd0, perr}, 32'd0);
      check("reset_busy",  {31'd0, busy}, 32'd0);
      reset = 1'b0;
      wait_ticks(4);

      // good frame 0xA5
      exp_q.push_back({2'b00, 8'hA5});
      send_frame(8'hA5, 1'b0, 1'b1);
      wait_ticks(4);
      check("a5_data", {24'd0, data}, 32'h0000_00A5);
      check("a5_busy_after", {31'd0, busy}, 32'd0);

      // false start: 4 low ticks, then high
      rx = 1'b0;
      wait_ticks(4);
      check("false_start_busy_mid", {31'd0, busy}, 32'd1);
      rx = 1'b1;
      wait_ticks(5);
      check("false_start_busy_end", {31'd0, busy}, 32'd0);
      wait_ticks(8);

      // framing error on 0x3C, line held low 40 ticks from the stop bit
      exp_q.push_back({2'b10, 8'hA5});
      send_frame(8'h3C, 1'b0, 1'b0);
      wait_ticks(24);
      check("break_busy_held", {31'd0, busy}, 32'd1);
      check("break_data_unchanged", {24'd0, data}, 32'h0000_00A5);
      rx = 1'b1;
      wait_ticks(1);
      check("break_exit_busy", {31'd0, busy}, 32'd0);
      wait_ticks(4);

      // back-to-back 0x00, 0xFF
      exp_q.push_back({2'b00, 8'h00});
      exp_q.push_back({2'b00, 8'hFF});
      send_frame(8'h00, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      wait_ticks(4);
      check("b2b_data", {24'd0, data}, 32'h0000_00FF);
      check("b2b_busy_after", {31'd0, busy}, 32'd0);

      // reset in the middle of data bit 3
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(d5a[i]);
      rx = d5a[3];
      wait_ticks(8);
      check("pre_reset_busy", {31'd0, busy}, 32'd1);
      @(posedge clock);
      #1;
      reset = 1'b1;
      rx    = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check("midreset_data",  {24'd0, data}, 32'd0);
      check("midreset_busy",  {31'd0, busy}, 32'd0);
      check("midreset_valid", {31'd0, valid}, 32'd0);
      check("midreset_ferr",  {31'd0, ferr}, 32'd0);
      check("midreset_perr",  {31'd0, perr}, 32'd0);
      wait_ticks(20);
      exp_q.push_back({2'b00, 8'h5A});
      send_frame(8'h5A, 1'b0, 1'b1);
      wait_ticks(4);
      check("after_reset_data", {24'd0, data}, 32'h0000_005A);

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones, so the even parity bit must be 1
      exp_q.push_back({2'b01, 8'h07});
      send_frame(8'h07, 1'b0, 1'b1);
      wait_ticks(4);
      exp_q.push_back({2'b00, 8'h07});
      send_frame(8'h07, 1'b1, 1'b1);
      wait_ticks(4);
`endif

      repeat (20) @(posedge clock);
      #1;
      check("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
